// File: rtl/ahb_sram_slave_pkg.sv
// Shared AHB-Lite encodings used by the SRAM slave front-end.
package ahb_sram_slave_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

endpackage

// File: rtl/ahb_sram_slave_lane.sv
// Byte-lane write mask and alignment check for one AHB address phase.
module ahb_lane_decode
    import ahb_sram_slave_pkg::*;
(
    input  logic [2:0] hsize,
    input  logic [1:0] addr_lo,
    output logic [3:0] we_mask,
    output logic       illegal
);

    always_comb begin
        we_mask = 4'b0000;
        illegal = 1'b0;
        case (hsize)
            HSIZE_BYTE: we_mask = 4'b0001 << addr_lo;
            HSIZE_HALF: begin
                we_mask = 4'b0011 << {addr_lo[1], 1'b0};
                illegal = addr_lo[0];
            end
            HSIZE_WORD: begin
                we_mask = 4'b1111;
                illegal = (addr_lo != 2'b00);
            end
            default:    illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave front-end for a single-port synchronous SRAM: wait states,
// write-then-read port conflict replay and two-cycle ERROR response.
module ahb_sram_slave
    import ahb_sram_slave_pkg::*;
#(
    parameter int ADDR_WIDTH  = 14,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic [1:0]            HRESP,
    output logic [31:0]           HRDATA,
    output logic                  mem_cs,
    output logic [3:0]            mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_di,
    input  logic [31:0]           mem_do
);

    typedef enum logic [2:0] {IDLE, RD, WR, WAIT, STALL_RD, ERR1, ERR2} state_t;

    localparam logic [2:0] WS = 3'(WAIT_STATES);

    state_t                state, state_nxt;
    logic [2:0]            cnt_p1;
    logic                  wr_p1;
    logic [ADDR_WIDTH-1:0] addr_p1;
    logic [3:0]            we_p1;

    logic [3:0] we_mask;
    logic       illegal;
    logic       accept, dphase, final_cyc, ready_st, take, wr_port, rd_now;
    logic       cs_raw;
    logic [3:0] we_raw;
    logic       unused_bits;

    ahb_lane_decode u_lane (
        .hsize   (HSIZE),
        .addr_lo (HADDR[1:0]),
        .we_mask (we_mask),
        .illegal (illegal)
    );

    assign accept    = HSEL & HREADY & HTRANS[1];
    assign dphase    = (state == RD) || (state == WR) || (state == WAIT);
    assign final_cyc = dphase && (cnt_p1 == 3'd0);
    assign ready_st  = (state == IDLE) || (state == ERR2) || final_cyc;
    assign take      = accept && ready_st;
    assign wr_port   = final_cyc && wr_p1;
    // Zero-wait reads go to the SRAM straight from the address phase unless a write owns the port.
    assign rd_now    = take && !illegal && !HWRITE && (WAIT_STATES == 0) && !wr_port;

    assign HREADYOUT   = !((dphase && !final_cyc) || (state == STALL_RD) || (state == ERR1));
    assign HRESP       = ((state == ERR1) || (state == ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign mem_di      = HWDATA;
    assign mem_cs      = cs_raw & ~rst;
    assign mem_we      = rst ? 4'b0000 : we_raw;
    assign unused_bits = ^{HADDR[31:ADDR_WIDTH+2], HTRANS[0]};

    // Address phase -> data phase (control)
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt_p1 <= 3'd0;
            wr_p1  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (take) begin
                cnt_p1 <= WS;
                wr_p1  <= HWRITE;
            end else if (cnt_p1 != 3'd0) begin
                cnt_p1 <= cnt_p1 - 3'd1;
            end
        end
    end

    // Address phase -> data phase (data)
    always_ff @(posedge clk) begin
        if (take) begin
            addr_p1 <= HADDR[ADDR_WIDTH+1:2];
            we_p1   <= we_mask;
        end
    end

    always_comb begin
        state_nxt = state;
        HRDATA    = '0;
        cs_raw    = 1'b0;
        we_raw    = 4'b0000;
        mem_addr  = addr_p1;
        case (state)
            RD, WR, WAIT: begin
                if (!final_cyc) state_nxt = WAIT;
                if (wr_port) begin
                    cs_raw = 1'b1;
                    we_raw = we_p1;
                end
                // Delayed read lands in the last wait cycle so data meets the final cycle.
                if (!wr_p1 && (cnt_p1 == 3'd1)) cs_raw = 1'b1;
                if (final_cyc && !wr_p1) HRDATA = mem_do;
            end
            STALL_RD: begin
                cs_raw    = 1'b1;
                state_nxt = RD;
            end
            ERR1:    state_nxt = ERR2;
            default: ;
        endcase
        if (ready_st) begin
            if (!take)
                state_nxt = IDLE;
            else if (illegal)
                state_nxt = ERR1;
            else if (!HWRITE && wr_port && (WAIT_STATES == 0))
                state_nxt = STALL_RD;
            else
                state_nxt = HWRITE ? WR : RD;
        end
        if (rd_now) begin
            cs_raw   = 1'b1;
            mem_addr = HADDR[ADDR_WIDTH+1:2];
        end
    end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench: one zero-wait slave and one two-wait slave, each with an SRAM model.
module tb_ahb_sram_slave;
    import ahb_sram_slave_pkg::*;

    localparam int AW = 14;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, preload;
    logic          hsel0, hsel1;
    logic [31:0]   haddr, hwdata;
    logic [1:0]    htrans;
    logic          hwrite;
    logic [2:0]    hsize;
    logic          hreadyout0, hreadyout1;
    logic [1:0]    hresp0, hresp1;
    logic [31:0]   hrdata0, hrdata1;
    logic          mem_cs0, mem_cs1;
    logic [3:0]    mem_we0, mem_we1;
    logic [AW-1:0] mem_addr0, mem_addr1;
    logic [31:0]   mem_di0, mem_di1, mem_do0, mem_do1;
    logic [31:0]   mem0 [0:(1<<AW)-1];
    logic [31:0]   mem1 [0:(1<<AW)-1];
    logic [31:0]   exp_rd [4];

    int total = 0;
    int bad   = 0;

    ahb_sram_slave #(.ADDR_WIDTH(AW), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hreadyout0),
        .HREADYOUT(hreadyout0), .HRESP(hresp0), .HRDATA(hrdata0),
        .mem_cs(mem_cs0), .mem_we(mem_we0), .mem_addr(mem_addr0),
        .mem_di(mem_di0), .mem_do(mem_do0)
    );

    ahb_sram_slave #(.ADDR_WIDTH(AW), .WAIT_STATES(2)) dut1 (
        .clk(clk), .rst(rst), .HSEL(hsel1), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hreadyout1),
        .HREADYOUT(hreadyout1), .HRESP(hresp1), .HRDATA(hrdata1),
        .mem_cs(mem_cs1), .mem_we(mem_we1), .mem_addr(mem_addr1),
        .mem_di(mem_di1), .mem_do(mem_do1)
    );

    always @(posedge clk) begin
        if (preload) begin
            mem0[16] <= 32'h1111_1111;
            mem0[9]  <= 32'hCAFE_F00D;
        end else if (mem_cs0) begin
            if (mem_we0 == 4'b0000) mem_do0 <= mem0[mem_addr0];
            else for (int i = 0; i < 4; i++)
                if (mem_we0[i]) mem0[mem_addr0][i*8 +: 8] <= mem_di0[i*8 +: 8];
        end
    end

    always @(posedge clk) begin
        if (preload) begin
            mem1[0] <= 32'hA000_0001;
            mem1[1] <= 32'hB000_0002;
            mem1[2] <= 32'hC000_0003;
            mem1[3] <= 32'hD000_0004;
        end else if (mem_cs1) begin
            if (mem_we1 == 4'b0000) mem_do1 <= mem1[mem_addr1];
            else for (int i = 0; i < 4; i++)
                if (mem_we1[i]) mem1[mem_addr1][i*8 +: 8] <= mem_di1[i*8 +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_rd = '{32'hA000_0001, 32'hB000_0002, 32'hC000_0003, 32'hD000_0004};
        rst = 1'b1; preload = 1'b1;
        hsel0 = 1'b0; hsel1 = 1'b0; haddr = '0; htrans = HTRANS_IDLE;
        hwrite = 1'b0; hsize = HSIZE_WORD; hwdata = '0;
        repeat (3) @(posedge clk);
        #1; preload = 1'b0;
        @(negedge clk);
        chk("rst_rdy0", hreadyout0, 1);
        chk("rst_resp0", hresp0, HRESP_OKAY);
        chk("rst_rdata0", hrdata0, 0);
        chk("rst_cs0", mem_cs0, 0);
        chk("rst_we0", mem_we0, 0);
        chk("rst_rdy1", hreadyout1, 1);
        step(); rst = 1'b0;

        // reset during a write data phase
        hsel0 = 1'b1; htrans = HTRANS_NONSEQ; hwrite = 1'b1; haddr = 32'h40;
        @(negedge clk); chk("rstwr_addr_cs", mem_cs0, 0);
        step(); htrans = HTRANS_IDLE; hwdata = 32'hBAD0_BAD0; rst = 1'b1;
        @(negedge clk); chk("rstwr_we_in_rst", mem_we0, 0);
        step(); rst = 1'b0;
        @(negedge clk); chk("rstwr_we_after", mem_we0, 0); chk("rstwr_rdy_after", hreadyout0, 1);
        step(); chk("rstwr_mem_keep", mem0[16], 32'h1111_1111);

        // word write then read back
        htrans = HTRANS_NONSEQ; hwrite = 1'b1; hsize = HSIZE_WORD; haddr = 32'h10;
        step(); htrans = HTRANS_IDLE; hwdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("wr_rdy", hreadyout0, 1); chk("wr_cs", mem_cs0, 1);
        chk("wr_we", mem_we0, 4'hF); chk("wr_addr", mem_addr0, 4);
        step(); htrans = HTRANS_NONSEQ; hwrite = 1'b0; haddr = 32'h10;
        @(negedge clk); chk("rd_cs_accept", mem_cs0, 1); chk("rd_we_accept", mem_we0, 0);
        step(); htrans = HTRANS_IDLE;
        @(negedge clk); chk("rd_rdy", hreadyout0, 1); chk("rd_data", hrdata0, 32'hDEAD_BEEF);
        step();

        // byte write at 0x13
        htrans = HTRANS_NONSEQ; hwrite = 1'b1; hsize = HSIZE_BYTE; haddr = 32'h13;
        step(); htrans = HTRANS_IDLE; hwdata = 32'hA5A5_A5A5;
        @(negedge clk); chk("bw_we", mem_we0, 4'b1000);
        step(); htrans = HTRANS_NONSEQ; hwrite = 1'b0; hsize = HSIZE_WORD; haddr = 32'h10;
        step(); htrans = HTRANS_IDLE;
        @(negedge clk); chk("bw_readback", hrdata0, 32'hA5AD_BEEF);
        step();

        // write 0x20 followed immediately by read 0x24
        htrans = HTRANS_NONSEQ; hwrite = 1'b1; haddr = 32'h20;
        step(); hwdata = 32'h1234_5678; hwrite = 1'b0; haddr = 32'h24;
        @(negedge clk);
        chk("cf_wr_rdy", hreadyout0, 1); chk("cf_wr_we", mem_we0, 4'hF);
        chk("cf_wr_addr", mem_addr0, 8);
        step(); htrans = HTRANS_IDLE;
        @(negedge clk);
        chk("cf_stall_rdy", hreadyout0, 0); chk("cf_stall_cs", mem_cs0, 1);
        chk("cf_stall_we", mem_we0, 0); chk("cf_stall_addr", mem_addr0, 9);
        chk("cf_stall_rdata", hrdata0, 0);
        step();
        @(negedge clk); chk("cf_rd_rdy", hreadyout0, 1); chk("cf_rd_data", hrdata0, 32'hCAFE_F00D);
        step();

        // misaligned word access, then a read accepted during ERR2
        htrans = HTRANS_NONSEQ; hwrite = 1'b0; hsize = HSIZE_WORD; haddr = 32'h22;
        @(negedge clk); chk("err_addr_cs", mem_cs0, 0);
        step(); htrans = HTRANS_IDLE;
        @(negedge clk);
        chk("err1_rdy", hreadyout0, 0); chk("err1_resp", hresp0, HRESP_ERROR);
        chk("err1_cs", mem_cs0, 0);
        step(); htrans = HTRANS_NONSEQ; haddr = 32'h10;
        @(negedge clk);
        chk("err2_rdy", hreadyout0, 1); chk("err2_resp", hresp0, HRESP_ERROR);
        chk("err2_accept_cs", mem_cs0, 1);
        step(); htrans = HTRANS_IDLE;
        @(negedge clk); chk("post_err_data", hrdata0, 32'hA5AD_BEEF); chk("post_err_resp", hresp0, HRESP_OKAY);
        step();

        // two-wait-state slave: single write
        hsel0 = 1'b0; hsel1 = 1'b1;
        htrans = HTRANS_NONSEQ; hwrite = 1'b1; haddr = 32'h30;
        step(); htrans = HTRANS_IDLE; hwdata = 32'h0BAD_CAFE;
        @(negedge clk); chk("ws2_wr_rdy_a", hreadyout1, 0); chk("ws2_wr_cs_a", mem_cs1, 0);
        step();
        @(negedge clk); chk("ws2_wr_rdy_b", hreadyout1, 0); chk("ws2_wr_cs_b", mem_cs1, 0);
        step();
        @(negedge clk);
        chk("ws2_wr_rdy_c", hreadyout1, 1); chk("ws2_wr_cs_c", mem_cs1, 1);
        chk("ws2_wr_we", mem_we1, 4'hF); chk("ws2_wr_addr", mem_addr1, 12);
        step(); chk("ws2_wr_mem", mem1[12], 32'h0BAD_CAFE);

        // two-wait-state slave: four pipelined read beats over 12 data cycles
        htrans = HTRANS_NONSEQ; hwrite = 1'b0; haddr = 32'h0;
        step();
        for (int c = 0; c < 12; c++) begin
            if (c / 3 < 3) begin
                htrans = HTRANS_SEQ;
                haddr  = 32'((c / 3 + 1) * 4);
            end else begin
                htrans = HTRANS_IDLE;
            end
            @(negedge clk);
            chk("ws2_rd_rdy", hreadyout1, 32'(c % 3 == 2));
            chk("ws2_rd_cs", mem_cs1, 32'(c % 3 == 1));
            chk("ws2_rd_data", hrdata1, (c % 3 == 2) ? exp_rd[c / 3] : 32'h0);
            step();
        end
        @(negedge clk); chk("ws2_idle_rdy", hreadyout1, 1); chk("ws2_idle_cs", mem_cs1, 0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
